// File: rtl/gcd_sched_pkg.sv
// Shared types and widths for the GCD job scheduler and its arbiter.
package gcd_sched_pkg;

    localparam int unsigned OPW  = 3;
    localparam int unsigned CNTW = 12;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_TIMEOUT = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        CPL
    } state_t;

endpackage

// File: rtl/gcd_job_scheduler_if.sv
// Request and completion channels of the GCD job scheduler.
interface gcd_job_scheduler_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = 3
);
    import gcd_sched_pkg::*;

    logic [NREQ-1:0]     REQ_VALID;
    logic [NREQ-1:0]     REQ_READY;
    logic [OPW*NREQ-1:0] REQ_OPCODE;
    logic [NREQ-1:0]     REQ_CT;
    logic [NREQ-1:0]     REQ_DBG;

    logic                CPL_VALID;
    logic                CPL_READY;
    logic [IDW-1:0]      CPL_ID;
    logic [1:0]          CPL_STATUS;
    logic [CNTW-1:0]     CPL_CYCLES;

    modport master (
        output REQ_VALID, REQ_OPCODE, REQ_CT, REQ_DBG, CPL_READY,
        input  REQ_READY, CPL_VALID, CPL_ID, CPL_STATUS, CPL_CYCLES
    );

    modport slave (
        input  REQ_VALID, REQ_OPCODE, REQ_CT, REQ_DBG, CPL_READY,
        output REQ_READY, CPL_VALID, CPL_ID, CPL_STATUS, CPL_CYCLES
    );

endinterface

// File: rtl/gcd_rr_arbiter.sv
// Round-robin grant over NREQ requesters with registered pointer.
// Build option GCD_SCHED_PRIO0_EN: requester 0 gets strict priority and leaves the pointer untouched.
module gcd_rr_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned IDW  = 3
) (
    input  logic            CLK,
    input  logic            RESETn,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_any
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic           prio_hit;
    int unsigned    idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        prio_hit  = 1'b0;
        idx       = 0;
`ifdef GCD_SCHED_PRIO0_EN
        if (req[0]) begin
            grant[0]  = 1'b1;
            grant_any = 1'b1;
            prio_hit  = 1'b1;
        end
`endif
        // Scan from the pointer, wrapping; first hit wins.
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    always_comb begin
        if (grant_id == IDW'(NREQ - 1))
            ptr_next = '0;
        else
            ptr_next = grant_id + 1'b1;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            ptr <= '0;
        else if (accept && !prio_hit)
            ptr <= ptr_next;
    end

endmodule

// File: rtl/gcd_job_scheduler.sv
// Shares one GCD core among NREQ requesters: arbitration, issue, done/watchdog, completion record.
// Build option GCD_SCHED_PRIO0_EN selects strict priority for requester 0 in the arbiter.
module gcd_job_scheduler
    import gcd_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned IDW     = 3,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                CLKEN,
    gcd_job_scheduler_if.slave  job,
    output logic                GCD_START,
    output logic [OPW-1:0]      GCD_OPCODE,
    output logic                GCD_CONSTANT_TIME,
    output logic                GCD_DEBUG_MODE,
    input  logic                GCD_DONE,
    input  logic [CNTW-1:0]     GCD_CYCLE_COUNT,
    output logic [IDW-1:0]      ARG_SEL,
    output logic                BUSY
);

    localparam logic [CNTW-1:0] WDOG_LAST = CNTW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] WDOG_CPL  = CNTW'(TIMEOUT);

    state_t          state, state_next;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic            accept;
    logic [OPW-1:0]  sel_op;
    logic            sel_ct;
    logic            sel_dbg;
    logic            done_r;
    logic            done_edge;
    logic [CNTW-1:0] wdog;
    logic            wdog_hit;

    assign accept    = CLKEN && (state == IDLE) && grant_any;
    assign done_edge = GCD_DONE && !done_r;
    assign wdog_hit  = (wdog == WDOG_LAST);

    gcd_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .req       (job.REQ_VALID),
        .accept    (accept),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_op  = '0;
        sel_ct  = 1'b0;
        sel_dbg = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_op  = job.REQ_OPCODE[i*OPW +: OPW];
                sel_ct  = job.REQ_CT[i];
                sel_dbg = job.REQ_DBG[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            state <= IDLE;
        else if (CLKEN)
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        GCD_START     = 1'b0;
        BUSY          = 1'b1;
        job.CPL_VALID = 1'b0;
        job.REQ_READY = '0;
        unique case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (CLKEN)
                    job.REQ_READY = grant;
                if (grant_any)
                    state_next = ISSUE;
            end
            ISSUE: begin
                GCD_START  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (done_edge || wdog_hit)
                    state_next = CPL;
            end
            CPL: begin
                job.CPL_VALID = 1'b1;
                if (job.CPL_READY)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // done_r follows the core in every state so a stale level never looks like a fresh edge.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            done_r            <= 1'b0;
            wdog              <= '0;
            GCD_OPCODE        <= '0;
            GCD_CONSTANT_TIME <= 1'b0;
            GCD_DEBUG_MODE    <= 1'b0;
            ARG_SEL           <= '0;
            job.CPL_ID        <= '0;
            job.CPL_STATUS    <= STAT_OK;
            job.CPL_CYCLES    <= '0;
        end else if (CLKEN) begin
            done_r <= GCD_DONE;
            if (accept) begin
                GCD_OPCODE        <= sel_op;
                GCD_CONSTANT_TIME <= sel_ct;
                GCD_DEBUG_MODE    <= sel_dbg;
                ARG_SEL           <= grant_id;
            end
            if (state == ISSUE)
                wdog <= '0;
            if (state == WAIT) begin
                wdog <= wdog + 1'b1;
                if (done_edge) begin
                    job.CPL_ID     <= ARG_SEL;
                    job.CPL_STATUS <= STAT_OK;
                    job.CPL_CYCLES <= GCD_CYCLE_COUNT;
                end else if (wdog_hit) begin
                    job.CPL_ID     <= ARG_SEL;
                    job.CPL_STATUS <= STAT_TIMEOUT;
                    job.CPL_CYCLES <= WDOG_CPL;
                end
            end
        end
    end

endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Directed bench for gcd_job_scheduler (default build, TIMEOUT=16).
module tb_gcd_job_scheduler;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        CLKEN = 1'b1;
    logic        gcd_start;
    logic [2:0]  gcd_opcode;
    logic        gcd_ct;
    logic        gcd_dbg;
    logic        gcd_done = 1'b0;
    logic [11:0] gcd_cnt = '0;
    logic [2:0]  arg_sel;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    gcd_job_scheduler_if #(.NREQ(3), .IDW(3)) bus ();

    gcd_job_scheduler #(
        .NREQ    (3),
        .IDW     (3),
        .TIMEOUT (16)
    ) dut (
        .CLK               (CLK),
        .RESETn            (RESETn),
        .CLKEN             (CLKEN),
        .job               (bus.slave),
        .GCD_START         (gcd_start),
        .GCD_OPCODE        (gcd_opcode),
        .GCD_CONSTANT_TIME (gcd_ct),
        .GCD_DEBUG_MODE    (gcd_dbg),
        .GCD_DONE          (gcd_done),
        .GCD_CYCLE_COUNT   (gcd_cnt),
        .ARG_SEL           (arg_sel),
        .BUSY              (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  valid;
        logic [8:0]  opcode;
        logic [2:0]  ct;
        logic [2:0]  dbg;
        logic [11:0] cnt;
        int          exp_id;
        logic [2:0]  exp_op;
        logic        exp_ct;
        logic        exp_dbg;
    } row_t;

    row_t rows[7];
    row_t r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},   32'(gcd_start), 0);
        check({tag, "_opcode"},  32'(gcd_opcode), 0);
        check({tag, "_ct"},      32'(gcd_ct), 0);
        check({tag, "_dbg"},     32'(gcd_dbg), 0);
        check({tag, "_argsel"},  32'(arg_sel), 0);
        check({tag, "_busy"},    32'(busy), 0);
        check({tag, "_ready"},   32'(bus.REQ_READY), 0);
        check({tag, "_cvalid"},  32'(bus.CPL_VALID), 0);
        check({tag, "_cid"},     32'(bus.CPL_ID), 0);
        check({tag, "_cstat"},   32'(bus.CPL_STATUS), 0);
        check({tag, "_ccycles"}, 32'(bus.CPL_CYCLES), 0);
    endtask

    // Full job with done edge: handshake, issue, completion, accept.
    task automatic run_job(input row_t j);
        int n;
        bus.REQ_VALID  = j.valid;
        bus.REQ_OPCODE = j.opcode;
        bus.REQ_CT     = j.ct;
        bus.REQ_DBG    = j.dbg;
        #1;
        n = 0;
        while (bus.REQ_READY == 0 && n < 20) begin
            tick();
            n++;
        end
        check("req_ready", 32'(bus.REQ_READY), 32'(1) << j.exp_id);
        tick();
        check("issue_start",  32'(gcd_start), 1);
        check("issue_opcode", 32'(gcd_opcode), 32'(j.exp_op));
        check("issue_ct",     32'(gcd_ct), 32'(j.exp_ct));
        check("issue_dbg",    32'(gcd_dbg), 32'(j.exp_dbg));
        check("issue_argsel", 32'(arg_sel), 32'(j.exp_id));
        check("issue_busy",   32'(busy), 1);
        tick();
        check("wait_start", 32'(gcd_start), 0);
        gcd_cnt  = j.cnt;
        gcd_done = 1'b1;
        n = 0;
        while (!bus.CPL_VALID && n < 30) begin
            tick();
            n++;
        end
        check("cpl_valid",   32'(bus.CPL_VALID), 1);
        check("cpl_id",      32'(bus.CPL_ID), 32'(j.exp_id));
        check("cpl_status",  32'(bus.CPL_STATUS), 0);
        check("cpl_cycles",  32'(bus.CPL_CYCLES), 32'(j.cnt));
        check("cpl_noready", 32'(bus.REQ_READY), 0);
        bus.REQ_VALID = '0;
        bus.CPL_READY = 1'b1;
        tick();
        bus.CPL_READY = 1'b0;
        gcd_done      = 1'b0;
        check("post_cpl_valid", 32'(bus.CPL_VALID), 0);
        check("post_cpl_busy",  32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int starts;
        int wait_en;

        rows[0] = '{3'b001, 9'b000_000_010, 3'b001, 3'b000, 12'h1F4, 0, 3'b010, 1'b1, 1'b0};
        rows[1] = '{3'b111, 9'b101_011_110, 3'b010, 3'b100, 12'h023, 1, 3'b011, 1'b1, 1'b0};
        rows[2] = '{3'b111, 9'b101_011_110, 3'b010, 3'b100, 12'h7FF, 2, 3'b101, 1'b0, 1'b1};
        rows[3] = '{3'b111, 9'b101_011_110, 3'b010, 3'b100, 12'h001, 0, 3'b110, 1'b0, 1'b0};
        rows[4] = '{3'b101, 9'b101_011_110, 3'b010, 3'b100, 12'hFFF, 2, 3'b101, 1'b0, 1'b1};
        rows[5] = '{3'b110, 9'b101_011_110, 3'b010, 3'b100, 12'h100, 1, 3'b011, 1'b1, 1'b0};
        rows[6] = '{3'b001, 9'b101_011_110, 3'b010, 3'b100, 12'h0C8, 0, 3'b110, 1'b0, 1'b0};

        bus.REQ_VALID  = '0;
        bus.REQ_OPCODE = '0;
        bus.REQ_CT     = '0;
        bus.REQ_DBG    = '0;
        bus.CPL_READY  = 1'b0;
        #12;
        check_all_zero("reset");
        RESETn = 1'b1;
        tick();

        for (int i = 0; i < 7; i++)
            run_job(rows[i]);

        // Timeout: requester 1, done never rises; pointer now at 1.
        bus.REQ_VALID  = 3'b010;
        bus.REQ_OPCODE = 9'b000_111_000;
        #1;
        check("to_ready", 32'(bus.REQ_READY), 32'b010);
        tick();
        bus.REQ_VALID = '0;
        n = 0;
        while (!bus.CPL_VALID && n < 40) begin
            tick();
            n++;
        end
        check("to_latency", 32'(n), 17);
        check("to_status",  32'(bus.CPL_STATUS), 1);
        check("to_cycles",  32'(bus.CPL_CYCLES), 16);
        check("to_id",      32'(bus.CPL_ID), 1);
        bus.CPL_READY = 1'b1;
        tick();
        bus.CPL_READY = 1'b0;
        gcd_cnt  = 12'h555;
        gcd_done = 1'b1;
        repeat (4) tick();
        check("late_done_cvalid", 32'(bus.CPL_VALID), 0);
        check("late_done_busy",   32'(busy), 0);

        // Stale done: level still high when the next job issues; pointer at 2.
        bus.REQ_VALID  = 3'b001;
        bus.REQ_OPCODE = 9'b000_000_001;
        bus.REQ_CT     = 3'b000;
        bus.REQ_DBG    = 3'b001;
        #1;
        check("stale_ready", 32'(bus.REQ_READY), 32'b001);
        tick();
        bus.REQ_VALID = '0;
        repeat (6) tick();
        check("stale_hold_cvalid", 32'(bus.CPL_VALID), 0);
        check("stale_hold_busy",   32'(busy), 1);
        gcd_done = 1'b0;
        tick();
        gcd_cnt  = 12'h0AB;
        gcd_done = 1'b1;
        tick();
        check("stale_cvalid", 32'(bus.CPL_VALID), 1);
        check("stale_cycles", 32'(bus.CPL_CYCLES), 32'h0AB);
        check("stale_status", 32'(bus.CPL_STATUS), 0);
        check("stale_id",     32'(bus.CPL_ID), 0);

        // Backpressure: record held, no new accept while pending.
        bus.REQ_VALID = 3'b111;
        for (int i = 0; i < 10; i++) begin
            check("bp_cvalid", 32'(bus.CPL_VALID), 1);
            check("bp_id",     32'(bus.CPL_ID), 0);
            check("bp_cycles", 32'(bus.CPL_CYCLES), 32'h0AB);
            check("bp_ready",  32'(bus.REQ_READY), 0);
            tick();
        end
        bus.REQ_VALID = '0;
        bus.CPL_READY = 1'b1;
        tick();
        bus.CPL_READY = 1'b0;
        gcd_done      = 1'b0;

        // CLKEN toggling: requester 2 (pointer at 1), timeout path.
        bus.REQ_VALID = 3'b100;
        CLKEN = 1'b0;
        #1;
        check("ce_ready_gated", 32'(bus.REQ_READY), 0);
        tick();
        check("ce_idle_busy", 32'(busy), 0);
        CLKEN = 1'b1;
        #1;
        check("ce_ready", 32'(bus.REQ_READY), 32'b100);
        tick();
        bus.REQ_VALID = '0;
        starts  = 0;
        wait_en = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            CLKEN = (cyc % 2 == 1);
            #1;
            if (bus.CPL_VALID)
                break;
            if (CLKEN) begin
                if (gcd_start)
                    starts++;
                else if (busy)
                    wait_en++;
            end
            tick();
        end
        CLKEN = 1'b1;
        check("ce_starts",  32'(starts), 1);
        check("ce_wait_en", 32'(wait_en), 16);
        check("ce_status",  32'(bus.CPL_STATUS), 1);
        check("ce_id",      32'(bus.CPL_ID), 2);
        bus.CPL_READY = 1'b1;
        tick();
        bus.CPL_READY = 1'b0;

        // Reset mid-WAIT; pointer at 0, moves to 1 on this grant.
        bus.REQ_VALID = 3'b001;
        #1;
        check("rst_job_ready", 32'(bus.REQ_READY), 32'b001);
        tick();
        bus.REQ_VALID = '0;
        tick();
        tick();
        check("rst_job_busy", 32'(busy), 1);
        #2;
        RESETn = 1'b0;
        #1;
        check_all_zero("midreset");
        #2;
        RESETn = 1'b1;
        tick();

        r = '{3'b101, 9'b101_011_110, 3'b010, 3'b100, 12'h3C3, 0, 3'b110, 1'b0, 1'b0};
        run_job(r);
        r = '{3'b100, 9'b101_011_110, 3'b010, 3'b100, 12'h0F0, 2, 3'b101, 1'b0, 1'b1};
        run_job(r);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gcd_job_scheduler.md
Name: gcd_job_scheduler

Overview:
- Shares one GCD core among NREQ requesters, e.g. APB control path, a DMA descriptor engine and a debug port.
- Round-robin arbitration selects one job at a time. The block drives the core's start pulse, opcode, constant-time and debug-mode inputs, and steers the operand mux to the winner.
- It detects the core's completion edge and enforces a watchdog timeout.
- Each result is returned as a completion record (requester ID, status, cycle count) over a valid/ready channel.

Parameters:
- NREQ, 3, number of requesters (2..8)
- IDW, 3, requester-ID width; must satisfy 2**IDW >= NREQ
- TIMEOUT, 4095, maximum CLKEN-qualified cycles in WAIT before the job is abandoned

Ports:
- CLK  in  1  clock
- RESETn  in  1  async active-low reset
- CLKEN  in  1  clock enable; every state/counter update is qualified by it
- REQ_VALID  in  NREQ  per-requester job request
- REQ_READY  out  NREQ  one-hot accept, at most one bit high
- REQ_OPCODE  in  3*NREQ  opcode; requester i uses bits [3i+2:3i]
- REQ_CT  in  NREQ  constant-time request per requester
- REQ_DBG  in  NREQ  debug-mode request per requester
- GCD_START  out  1  single-cycle start pulse to the core
- GCD_OPCODE  out  3  registered opcode
- GCD_CONSTANT_TIME  out  1  registered constant-time flag
- GCD_DEBUG_MODE  out  1  registered debug-mode flag
- GCD_DONE  in  1  core done (level)
- GCD_CYCLE_COUNT  in  12  core cycle count
- ARG_SEL  out  IDW  operand-mux select, equal to the ID of the current job
- CPL_VALID  out  1  completion record valid
- CPL_READY  in  1  completion consumer ready
- CPL_ID  out  IDW  requester ID of the completed job
- CPL_STATUS  out  2  00 = OK, 01 = timeout
- CPL_CYCLES  out  12  captured GCD_CYCLE_COUNT, or TIMEOUT on timeout
- BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; done_r 0; watchdog 0.
- Nothing changes when CLKEN=0, except that REQ_READY is forced to 0 in that cycle.
- IDLE:
  - If any REQ_VALID is set, the arbiter picks the first requester at or after the pointer, wrapping.
  - REQ_READY[w] is asserted combinationally in that cycle; the handshake completes there.
  - Latch opcode, CT and DBG; set ARG_SEL=w; move the pointer to w+1 mod NREQ. Next state ISSUE.
- ISSUE:
  - GCD_START=1 for exactly one CLKEN cycle; clear the watchdog.
  - Next state WAIT.
  - The issue latency from handshake to start is 1 CLKEN cycle.
- WAIT:
  - Watchdog increments each cycle.
  - On done_edge = GCD_DONE & ~done_r: capture GCD_CYCLE_COUNT, STATUS=OK, go to CPL.
  - If the watchdog reaches TIMEOUT first: STATUS=timeout, CPL_CYCLES=TIMEOUT, go to CPL.
  - If done_edge and the timeout occur in the same cycle, done wins and STATUS=OK.
- done_r tracks GCD_DONE in every state. A done level already high at ISSUE does not complete the new job; only a fresh rising edge does.
- CPL:
  - CPL_VALID=1; CPL_ID, CPL_STATUS and CPL_CYCLES stay stable until CPL_VALID & CPL_READY.
  - After the handshake, go to IDLE. A new arbitration can occur no earlier than the next CLKEN cycle.
  - No back-to-back issue while a completion is pending; the block holds at most one job.
- Timeout: a late done edge for an abandoned job arriving in IDLE or CPL is ignored. A late done arriving in WAIT of the next job is accepted; software must reset the core after a timeout.
- GCD_OPCODE, GCD_CONSTANT_TIME, GCD_DEBUG_MODE and ARG_SEL hold from ISSUE through CPL, so operands are stable for the whole job.
- Reset asserted mid-job returns to IDLE immediately. No completion is emitted and the pointer returns to 0.
- Requesters that deassert REQ_VALID before accept are legal; no job is lost or duplicated.

Optional Feature:
- Macro GCD_SCHED_PRIO0_EN.
- Defined: requester 0 has strict priority. When REQ_VALID[0] is set it always wins, and the pointer is not updated on its grants. The other requesters round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters as above.

Decomposition:
- Package gcd_sched_pkg holds:
  - state enum: IDLE, ISSUE, WAIT, CPL
  - status constants: STAT_OK = 2'b00, STAT_TIMEOUT = 2'b01
  - opcode width constant (3)
  - cycle-count width constant (12)
- Sub-module gcd_rr_arbiter:
  - NREQ-wide, combinational grant from the request vector and pointer, plus the registered pointer update.
  - Carries the GCD_SCHED_PRIO0_EN variant.

Test Plan:
- Single job: REQ_VALID=001, opcode 3'b010, CT=1 → READY=001 the same cycle; GCD_START one cycle later with GCD_OPCODE=010 and GCD_CONSTANT_TIME=1. With done rising and cycle_count=0x1F4: CPL_VALID, CPL_ID=0, STATUS=00, CPL_CYCLES=0x1F4.
- Fairness: all three requesters valid continuously, each job completing → grant order 0,1,2,0,1,2, ARG_SEL following the same order. With GCD_SCHED_PRIO0_EN: order 0,0,0…
- Timeout: TIMEOUT=16, done never rises → CPL after 16 WAIT cycles with STATUS=01 and CPL_CYCLES=16. A late done edge in IDLE produces no completion.
- Stale done: GCD_DONE held high from the previous job at ISSUE → no completion until GCD_DONE falls and rises again.
- Backpressure/CLKEN: CPL_READY=0 for 10 cycles → the record stays stable and REQ_READY stays 0. CLKEN toggling 1/0 → the start pulse lasts one enabled cycle and the watchdog counts only enabled cycles.
- Reset mid-WAIT: RESETn pulsed low → all outputs 0 and state IDLE; a subsequent request from requester 2 is granted normally.
